// File: rtl/unified_memory_arbiter.sv
// unified_memory_arbiter
// Shares one single-port unified instruction/data memory between the core's
// instruction-fetch requester and its load/store requester.
// Ports:
//   i_clk, i_arst                 clock, asynchronous active-high reset
//   i_fetch*/o_fetch*             fetch request, combinational grant, registered response
//   i_data*/o_data*               load/store request, combinational grant, registered response
//   o_mem*/i_memReadData          memory address/write drive and combinational read data
// Parameter FIXED_PRIORITY: 0 = round-robin on conflict, 1 = data port always wins.
module unified_memory_arbiter #(
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_arst,
    input  logic        i_fetchReq,
    input  logic [31:0] i_fetchAddr,
    output logic        o_fetchGnt,
    output logic        o_fetchRspValid,
    output logic [31:0] o_fetchRspData,
    output logic        o_fetchRspError,
    input  logic        i_dataReq,
    input  logic        i_dataWe,
    input  logic [31:0] i_dataAddr,
    input  logic [31:0] i_dataWdata,
    output logic        o_dataGnt,
    output logic        o_dataRspValid,
    output logic [31:0] o_dataRspData,
    output logic        o_dataRspError,
    output logic [31:0] o_memAddr,
    output logic        o_memWriteEnable,
    output logic [31:0] o_memWriteData,
    input  logic [31:0] i_memReadData
);

    localparam int unsigned DW = 32;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } grant_e;

    grant_e          last_grant_q, last_grant_d;
    logic            fetch_gnt_c, data_gnt_c, data_wins_c;
    logic            fetch_aligned_c, data_aligned_c;

    logic            fetch_rsp_valid_q, fetch_rsp_valid_d;
    logic [DW-1:0]   fetch_rsp_data_q, fetch_rsp_data_d;
    logic            fetch_rsp_error_q, fetch_rsp_error_d;
    logic            data_rsp_valid_q, data_rsp_valid_d;
    logic [DW-1:0]   data_rsp_data_q, data_rsp_data_d;
    logic            data_rsp_error_q, data_rsp_error_d;

    // Arbitration and memory drive; grants are suppressed while in reset.
    always_comb begin
        fetch_aligned_c = (i_fetchAddr[1:0] == 2'b00);
        data_aligned_c  = (i_dataAddr[1:0] == 2'b00);
        // On conflict, data wins if fixed-priority or fetch was granted last.
        data_wins_c     = FIXED_PRIORITY ? 1'b1 : (last_grant_q == GNT_FETCH);
        data_gnt_c      = !i_arst && i_dataReq && (!i_fetchReq || data_wins_c);
        fetch_gnt_c     = !i_arst && i_fetchReq && (!i_dataReq || !data_wins_c);
        o_memAddr        = data_gnt_c ? i_dataAddr : i_fetchAddr;
        o_memWriteData   = i_dataWdata;
        // Misaligned stores are accepted but never reach memory.
        o_memWriteEnable = data_gnt_c && i_dataWe && data_aligned_c;
    end

    assign o_fetchGnt = fetch_gnt_c;
    assign o_dataGnt  = data_gnt_c;

    // Next-state for grant history and response capture.
    always_comb begin
        last_grant_d      = last_grant_q;
        fetch_rsp_valid_d = fetch_gnt_c;
        fetch_rsp_data_d  = fetch_rsp_data_q;
        fetch_rsp_error_d = fetch_rsp_error_q;
        data_rsp_valid_d  = data_gnt_c;
        data_rsp_data_d   = data_rsp_data_q;
        data_rsp_error_d  = data_rsp_error_q;

        if (fetch_gnt_c) begin
            last_grant_d      = GNT_FETCH;
            fetch_rsp_data_d  = fetch_aligned_c ? i_memReadData : '0;
            fetch_rsp_error_d = !fetch_aligned_c;
        end else if (data_gnt_c) begin
            last_grant_d      = GNT_DATA;
        end

        if (data_gnt_c) begin
            // Stores and misaligned loads return zero data.
            data_rsp_data_d  = (data_aligned_c && !i_dataWe) ? i_memReadData : '0;
            data_rsp_error_d = !data_aligned_c;
        end
    end

    // State registers; reset discards any pending response.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            last_grant_q      <= GNT_DATA;
            fetch_rsp_valid_q <= 1'b0;
            fetch_rsp_data_q  <= '0;
            fetch_rsp_error_q <= 1'b0;
            data_rsp_valid_q  <= 1'b0;
            data_rsp_data_q   <= '0;
            data_rsp_error_q  <= 1'b0;
        end else begin
            last_grant_q      <= last_grant_d;
            fetch_rsp_valid_q <= fetch_rsp_valid_d;
            fetch_rsp_data_q  <= fetch_rsp_data_d;
            fetch_rsp_error_q <= fetch_rsp_error_d;
            data_rsp_valid_q  <= data_rsp_valid_d;
            data_rsp_data_q   <= data_rsp_data_d;
            data_rsp_error_q  <= data_rsp_error_d;
        end
    end

    assign o_fetchRspValid = fetch_rsp_valid_q;
    assign o_fetchRspData  = fetch_rsp_data_q;
    assign o_fetchRspError = fetch_rsp_error_q;
    assign o_dataRspValid  = data_rsp_valid_q;
    assign o_dataRspData   = data_rsp_data_q;
    assign o_dataRspError  = data_rsp_error_q;

endmodule

// File: tb/tb_unified_memory_arbiter.sv
// Directed bench for unified_memory_arbiter: a round-robin instance and a
// fixed-priority instance share stimulus, each with its own memory model.
module tb_unified_memory_arbiter;

    logic        clk = 1'b0;
    logic        arst;
    logic        fetch_req, data_req, data_we;
    logic [31:0] fetch_addr, data_addr, data_wdata;

    logic        rr_fgnt, rr_fvalid, rr_ferr, rr_dgnt, rr_dvalid, rr_derr, rr_we;
    logic [31:0] rr_fdata, rr_ddata, rr_maddr, rr_mwdata, rr_mrdata;
    logic        fp_fgnt, fp_fvalid, fp_ferr, fp_dgnt, fp_dvalid, fp_derr, fp_we;
    logic [31:0] fp_fdata, fp_ddata, fp_maddr, fp_mwdata, fp_mrdata;

    logic [31:0] mem_rr [64];
    logic [31:0] mem_fp [64];

    int cmps = 0;
    int errs = 0;

    always #5 clk = ~clk;

    unified_memory_arbiter #(.FIXED_PRIORITY(1'b0)) dut_rr (
        .i_clk(clk), .i_arst(arst),
        .i_fetchReq(fetch_req), .i_fetchAddr(fetch_addr), .o_fetchGnt(rr_fgnt),
        .o_fetchRspValid(rr_fvalid), .o_fetchRspData(rr_fdata), .o_fetchRspError(rr_ferr),
        .i_dataReq(data_req), .i_dataWe(data_we), .i_dataAddr(data_addr), .i_dataWdata(data_wdata),
        .o_dataGnt(rr_dgnt), .o_dataRspValid(rr_dvalid), .o_dataRspData(rr_ddata),
        .o_dataRspError(rr_derr), .o_memAddr(rr_maddr), .o_memWriteEnable(rr_we),
        .o_memWriteData(rr_mwdata), .i_memReadData(rr_mrdata)
    );

    unified_memory_arbiter #(.FIXED_PRIORITY(1'b1)) dut_fp (
        .i_clk(clk), .i_arst(arst),
        .i_fetchReq(fetch_req), .i_fetchAddr(fetch_addr), .o_fetchGnt(fp_fgnt),
        .o_fetchRspValid(fp_fvalid), .o_fetchRspData(fp_fdata), .o_fetchRspError(fp_ferr),
        .i_dataReq(data_req), .i_dataWe(data_we), .i_dataAddr(data_addr), .i_dataWdata(data_wdata),
        .o_dataGnt(fp_dgnt), .o_dataRspValid(fp_dvalid), .o_dataRspData(fp_ddata),
        .o_dataRspError(fp_derr), .o_memAddr(fp_maddr), .o_memWriteEnable(fp_we),
        .o_memWriteData(fp_mwdata), .i_memReadData(fp_mrdata)
    );

    // Single-port memory models: combinational read, write on rising edge.
    assign rr_mrdata = mem_rr[rr_maddr[7:2]];
    assign fp_mrdata = mem_fp[fp_maddr[7:2]];
    always @(posedge clk) begin
        if (rr_we) mem_rr[rr_maddr[7:2]] <= rr_mwdata;
        if (fp_we) mem_fp[fp_maddr[7:2]] <= fp_mwdata;
    end

    task automatic idle_inputs();
        fetch_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
        fetch_addr = 32'h0; data_addr = 32'h0; data_wdata = 32'h0;
    endtask

    task automatic test_reset();
        arst = 1'b1;
        idle_inputs();
        fetch_req = 1'b1; data_req = 1'b1; data_we = 1'b1; data_addr = 32'h10;
        #2;
        cmps++; if (rr_fgnt !== 1'b0 || rr_dgnt !== 1'b0 || rr_we !== 1'b0) begin
            errs++; $display("FAIL reset_gnt: fgnt=%b dgnt=%b we=%b required 0 0 0", rr_fgnt, rr_dgnt, rr_we); end
        cmps++; if (rr_fvalid !== 1'b0 || rr_dvalid !== 1'b0 || rr_fdata !== 32'h0 || rr_ddata !== 32'h0 || rr_ferr !== 1'b0 || rr_derr !== 1'b0) begin
            errs++; $display("FAIL reset_rsp: fv=%b dv=%b fd=%h dd=%h fe=%b de=%b required all 0", rr_fvalid, rr_dvalid, rr_fdata, rr_ddata, rr_ferr, rr_derr); end
        idle_inputs();
        @(negedge clk); arst = 1'b0;
        // Fetch accepted, then reset asserted while its response is showing.
        @(negedge clk); fetch_req = 1'b1; fetch_addr = 32'h8;
        @(posedge clk); #1;
        cmps++; if (rr_fvalid !== 1'b1 || rr_fdata !== 32'hDEADBEEF) begin
            errs++; $display("FAIL reset_pre_rsp: fv=%b fd=%h required 1 deadbeef", rr_fvalid, rr_fdata); end
        #1 arst = 1'b1; #1;
        cmps++; if (rr_fvalid !== 1'b0 || rr_fdata !== 32'h0 || rr_ferr !== 1'b0 || rr_fgnt !== 1'b0) begin
            errs++; $display("FAIL reset_mid_rsp: fv=%b fd=%h fe=%b fgnt=%b required 0 0 0 0", rr_fvalid, rr_fdata, rr_ferr, rr_fgnt); end
        idle_inputs();
        @(negedge clk); arst = 1'b0;
        // First conflict after reset: fetch wins in round-robin, data in fixed.
        @(negedge clk); fetch_req = 1'b1; fetch_addr = 32'h8; data_req = 1'b1; data_addr = 32'h10;
        #1;
        cmps++; if (rr_fgnt !== 1'b1 || rr_dgnt !== 1'b0) begin
            errs++; $display("FAIL reset_first_conflict_rr: fgnt=%b dgnt=%b required 1 0", rr_fgnt, rr_dgnt); end
        cmps++; if (fp_fgnt !== 1'b0 || fp_dgnt !== 1'b1) begin
            errs++; $display("FAIL reset_first_conflict_fp: fgnt=%b dgnt=%b required 0 1", fp_fgnt, fp_dgnt); end
        @(negedge clk); idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_single_fetch();
        @(negedge clk); fetch_req = 1'b1; fetch_addr = 32'h8; #1;
        cmps++; if (rr_fgnt !== 1'b1 || rr_dgnt !== 1'b0 || rr_maddr !== 32'h8) begin
            errs++; $display("FAIL fetch_gnt: fgnt=%b dgnt=%b addr=%h required 1 0 00000008", rr_fgnt, rr_dgnt, rr_maddr); end
        @(posedge clk); #1;
        cmps++; if (rr_fvalid !== 1'b1 || rr_fdata !== 32'hDEADBEEF || rr_ferr !== 1'b0 || rr_dvalid !== 1'b0) begin
            errs++; $display("FAIL fetch_rsp: fv=%b fd=%h fe=%b dv=%b required 1 deadbeef 0 0", rr_fvalid, rr_fdata, rr_ferr, rr_dvalid); end
        @(negedge clk); idle_inputs();
        @(posedge clk); #1;
        cmps++; if (rr_fvalid !== 1'b0) begin
            errs++; $display("FAIL fetch_rsp_drop: fv=%b required 0", rr_fvalid); end
    endtask

    task automatic test_store_load();
        @(negedge clk); data_req = 1'b1; data_we = 1'b1; data_addr = 32'h10; data_wdata = 32'h12345678; #1;
        cmps++; if (rr_dgnt !== 1'b1 || rr_we !== 1'b1 || rr_maddr !== 32'h10 || rr_mwdata !== 32'h12345678) begin
            errs++; $display("FAIL store_drive: dgnt=%b we=%b addr=%h wd=%h required 1 1 00000010 12345678", rr_dgnt, rr_we, rr_maddr, rr_mwdata); end
        @(posedge clk); #1;
        cmps++; if (rr_dvalid !== 1'b1 || rr_ddata !== 32'h0 || rr_derr !== 1'b0) begin
            errs++; $display("FAIL store_rsp: dv=%b dd=%h de=%b required 1 0 0", rr_dvalid, rr_ddata, rr_derr); end
        @(negedge clk); data_we = 1'b0; data_wdata = 32'h0; #1;
        cmps++; if (rr_dgnt !== 1'b1 || rr_we !== 1'b0) begin
            errs++; $display("FAIL load_drive: dgnt=%b we=%b required 1 0", rr_dgnt, rr_we); end
        @(posedge clk); #1;
        cmps++; if (rr_dvalid !== 1'b1 || rr_ddata !== 32'h12345678 || rr_derr !== 1'b0) begin
            errs++; $display("FAIL load_rsp: dv=%b dd=%h de=%b required 1 12345678 0", rr_dvalid, rr_ddata, rr_derr); end
        @(negedge clk); idle_inputs();
        @(posedge clk); #1;
        cmps++; if (rr_dvalid !== 1'b0) begin
            errs++; $display("FAIL load_rsp_drop: dv=%b required 0", rr_dvalid); end
    endtask

    // Last grant before this test was data, so fetch wins first.
    task automatic test_round_robin();
        logic exp_f [4];
        exp_f[0] = 1'b1; exp_f[1] = 1'b0; exp_f[2] = 1'b1; exp_f[3] = 1'b0;
        @(negedge clk); fetch_req = 1'b1; fetch_addr = 32'h8; data_req = 1'b1; data_addr = 32'h10;
        for (int i = 0; i < 4; i++) begin
            #1;
            cmps++; if (rr_fgnt !== exp_f[i] || rr_dgnt !== !exp_f[i]) begin
                errs++; $display("FAIL rr_gnt[%0d]: fgnt=%b dgnt=%b required %b %b", i, rr_fgnt, rr_dgnt, exp_f[i], !exp_f[i]); end
            @(posedge clk); #1;
            cmps++; if (rr_fvalid !== exp_f[i] || rr_dvalid !== !exp_f[i]) begin
                errs++; $display("FAIL rr_rsp[%0d]: fv=%b dv=%b required %b %b", i, rr_fvalid, rr_dvalid, exp_f[i], !exp_f[i]); end
            if (exp_f[i]) begin
                cmps++; if (rr_fdata !== 32'hDEADBEEF) begin
                    errs++; $display("FAIL rr_fdata[%0d]: %h required deadbeef", i, rr_fdata); end
            end else begin
                cmps++; if (rr_ddata !== 32'h12345678) begin
                    errs++; $display("FAIL rr_ddata[%0d]: %h required 12345678", i, rr_ddata); end
            end
            @(negedge clk);
        end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_fixed_priority();
        @(negedge clk); fetch_req = 1'b1; fetch_addr = 32'h8; data_req = 1'b1; data_addr = 32'h10;
        for (int i = 0; i < 3; i++) begin
            #1;
            cmps++; if (fp_fgnt !== 1'b0 || fp_dgnt !== 1'b1) begin
                errs++; $display("FAIL fp_gnt[%0d]: fgnt=%b dgnt=%b required 0 1", i, fp_fgnt, fp_dgnt); end
            @(posedge clk); #1;
            cmps++; if (fp_dvalid !== 1'b1 || fp_fvalid !== 1'b0 || fp_ddata !== 32'h12345678) begin
                errs++; $display("FAIL fp_rsp[%0d]: dv=%b fv=%b dd=%h required 1 0 12345678", i, fp_dvalid, fp_fvalid, fp_ddata); end
            @(negedge clk);
        end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_misaligned_store();
        @(negedge clk); data_req = 1'b1; data_we = 1'b1; data_addr = 32'h13; data_wdata = 32'hCAFEF00D; #1;
        cmps++; if (rr_dgnt !== 1'b1 || rr_we !== 1'b0) begin
            errs++; $display("FAIL misaligned_drive: dgnt=%b we=%b required 1 0", rr_dgnt, rr_we); end
        @(posedge clk); #1;
        cmps++; if (rr_dvalid !== 1'b1 || rr_derr !== 1'b1 || rr_ddata !== 32'h0) begin
            errs++; $display("FAIL misaligned_rsp: dv=%b de=%b dd=%h required 1 1 0", rr_dvalid, rr_derr, rr_ddata); end
        cmps++; if (mem_rr[4] !== 32'h12345678) begin
            errs++; $display("FAIL misaligned_mem: word 0x10=%h required 12345678", mem_rr[4]); end
        // Misaligned fetch: accepted with error and zero data.
        @(negedge clk); idle_inputs(); fetch_req = 1'b1; fetch_addr = 32'h9;
        @(posedge clk); #1;
        cmps++; if (rr_fvalid !== 1'b1 || rr_ferr !== 1'b1 || rr_fdata !== 32'h0) begin
            errs++; $display("FAIL misaligned_fetch: fv=%b fe=%b fd=%h required 1 1 0", rr_fvalid, rr_ferr, rr_fdata); end
        @(negedge clk); idle_inputs();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem_rr[i] = 32'h0;
            mem_fp[i] = 32'h0;
        end
        mem_rr[2] = 32'hDEADBEEF;
        mem_fp[2] = 32'hDEADBEEF;
        test_reset();
        test_single_fetch();
        test_store_load();
        test_round_robin();
        test_fixed_priority();
        test_misaligned_store();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

endmodule
